i2c_write_sequencer: RTL
========================

// Module: i2c_write_sequencer
// PURPOSE
// Command-level controller in front of I2C_Master. Accepts one write command (7-bit slave addr + 0..MAX_BYTES data
// bytes) and sequences the master's En/Start/Stop/tx_data pins: START+addr, data bytes, STOP, with per-byte timeout.
// Used by the AXI4-Lite I2C wrapper and the LED-slave demo so software never bit-times the master.
// PARAMETERS
// MAX_BYTES    4       max data bytes per command (1..8)
// TIMEOUT_CYC  100000  max cycles in any wait state before abort
// STOP_GAP     20      idle cycles after m_stop before done/cmd_ready
// PORTS
// clk          in   1                 system clock, rising edge
// reset        in   1                 asynchronous, active-low (0 = reset)
// cmd_valid    in   1                 command present
// cmd_ready    out  1                 sequencer idle, accepts command
// cmd_addr     in   7                 slave address; sent as {cmd_addr,1'b0}
// cmd_len      in   $clog2(MAX_BYTES+1)  data byte count, 0 = address-only probe
// cmd_data     in   8*MAX_BYTES       byte k at [8k+7:8k], byte 0 sent first
// busy         out  1                 command in progress (accept .. done)
// done         out  1                 1-cycle pulse, command finished
// timeout_err  out  1                 1-cycle pulse with done when aborted by timeout
// m_en         out  1                 -> I2C_Master.I2C_En
// m_start      out  1                 -> I2C_Master.I2C_Start (1-cycle pulse)
// m_stop       out  1                 -> I2C_Master.I2C_Stop (1-cycle pulse)
// m_tx_data    out  8                 -> I2C_Master.tx_data
// m_tx_done    in   1                 <- I2C_Master.tx_done (byte shifted)
// m_ready      in   1                 <- I2C_Master.ready (HOLD after ACK)
// BEHAVIOUR
// - Reset (async, reset=0): state IDLE; cmd_ready=1; busy, done, timeout_err, m_en, m_start, m_stop=0; m_tx_data=0.
// - Accept on cmd_valid&&cmd_ready (cycle 0): latch addr/len/data; cmd_ready=0, busy=1 from cycle 1.
//   cmd_len>MAX_BYTES is clamped to MAX_BYTES.
// - FSM: IDLE -> START -> WAIT_DONE -> WAIT_RDY -> {LOAD -> WAIT_DONE | STOP} -> GAP -> DONE -> IDLE.
// - START (cycle 1): m_en=1, m_start=1 one cycle, m_tx_data={addr,0}. byte counter=0.
// - WAIT_DONE: hold until m_tx_done=1, then WAIT_RDY. WAIT_RDY: hold until m_ready=1.
//   Ready seen: if counter<len -> LOAD, else -> STOP.
// - LOAD (1 cycle): m_tx_data=data byte[counter], counter++, -> WAIT_DONE.
//   LOAD's 1 cycle masks a stale tx_done; m_start not re-pulsed.
// - STOP: m_stop=1 one cycle; m_en stays 1. GAP: m_en=1, count STOP_GAP cycles. DONE: done=1 one cycle, m_en=0, busy=0.
// - IDLE: cmd_ready=1, busy=0, m_en=0; m_tx_data holds last value.
// - Timeout: counter clears on every state entry, counts in WAIT_DONE/WAIT_RDY.
//   At TIMEOUT_CYC -> STOP, set abort flag; DONE pulses done and timeout_err together.
// - m_tx_done and m_ready are level-sampled in their own state only; pulses in other states are ignored.
// - cmd_valid while busy: ignored, not queued; cmd_data changes after accept have no effect.
// - done and cmd_ready never high in same cycle; next accept earliest 1 cycle after done.
// - Reset mid-command: outputs drop immediately, no STOP emitted (master is reset by the same reset).
// TESTING
// - addr=0x24, len=1, data=0x01, model master/slave:
//   m_start pulse with m_tx_data=0x48; after ready, m_tx_data=0x01; one m_stop; done once; LED=0x01.
// - len=3, data=0x33_22_11: m_tx_data sequence 0x48,0x11,0x22,0x33;
//   exactly 4 tx_done/ready cycles; one stop; timeout_err=0.
// - len=0: only address byte sent, m_stop after first ready, done after STOP_GAP+1 cycles.
// - m_tx_done tied 0, TIMEOUT_CYC=50: abort 50 cycles after entering WAIT_DONE;
//   m_stop pulses; done & timeout_err pulse together.
// - second cmd_valid held during busy: cmd_ready=0, not accepted until cycle after done; then runs normally.
// - reset=0 during WAIT_RDY of byte 1: same cycle m_en=0, busy=0, cmd_ready=1; a new command after release completes.

Source files
------------

// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer
// Command-level front end for I2C_Master. It takes one write command (7-bit
// address plus 0..MAX_BYTES data bytes) and drives the master's enable,
// start, stop and tx_data pins: START with the address byte, each data
// byte, then STOP. Every wait on the master is guarded by a timeout that
// aborts the command through STOP and reports timeout_err alongside done.

module i2c_write_sequencer #(
    parameter int  MAX_BYTES   = 4,
    parameter int  TIMEOUT_CYC = 100000,
    parameter int  STOP_GAP    = 20,
    localparam int LEN_W       = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [6:0]             cmd_addr,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic [8*MAX_BYTES-1:0] cmd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic                   m_en,
    output logic                   m_start,
    output logic                   m_stop,
    output logic [7:0]             m_tx_data,
    input  logic                   m_tx_done,
    input  logic                   m_ready
);

    // One counter serves both the wait-state timeout and the post-STOP gap,
    // so it must be wide enough for the larger of the two.
    localparam int CNT_MAX = (TIMEOUT_CYC > STOP_GAP) ? TIMEOUT_CYC : STOP_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((STOP_GAP > 0) ? (STOP_GAP - 1) : 0);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_WAIT_RDY  = 3'd3,
        ST_LOAD      = 3'd4,
        ST_STOP      = 3'd5,
        ST_GAP       = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

    state_t                 state_q,       state_d;
    logic [LEN_W-1:0]       len_q,         len_d;
    logic [8*MAX_BYTES-1:0] data_q,        data_d;
    logic [LEN_W-1:0]       byte_cnt_q,    byte_cnt_d;
    logic [CNT_W-1:0]       cnt_q,         cnt_d;
    logic                   abort_q,       abort_d;
    logic                   cmd_ready_q,   cmd_ready_d;
    logic                   busy_q,        busy_d;
    logic                   done_q,        done_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   m_en_q,        m_en_d;
    logic                   m_start_q,     m_start_d;
    logic                   m_stop_q,      m_stop_d;
    logic [7:0]             m_tx_data_q,   m_tx_data_d;

    // Requests longer than the buffer are truncated to MAX_BYTES.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] r;
        if (len > LEN_MAX) begin
            r = LEN_MAX;
        end else begin
            r = len;
        end
        return r;
    endfunction

    // Byte k of the latched payload; idx is always below the clamped length.
    function automatic logic [7:0] sel_byte(input logic [8*MAX_BYTES-1:0] data,
                                            input logic [LEN_W-1:0]       idx);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (idx == LEN_W'(k)) begin
                r = data[8*k +: 8];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Next-state, datapath and registered-output decode for the sequencer.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        data_d      = data_q;
        byte_cnt_d  = byte_cnt_q;
        abort_d     = abort_q;
        m_tx_data_d = m_tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = ST_START;
                    len_d       = clamp_len(cmd_len);
                    data_d      = cmd_data;
                    byte_cnt_d  = '0;
                    abort_d     = 1'b0;
                    m_tx_data_d = {cmd_addr, 1'b0};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (m_tx_done) begin
                    state_d = ST_WAIT_RDY;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_STOP;
                    abort_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_RDY: begin
                if (m_ready) begin
                    if (byte_cnt_q < len_q) begin
                        state_d     = ST_LOAD;
                        m_tx_data_d = sel_byte(data_q, byte_cnt_q);
                        byte_cnt_d  = byte_cnt_q + LEN_W'(1);
                    end else begin
                        state_d = ST_STOP;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_STOP;
                    abort_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_LOAD: begin
                // Spending one cycle here hides the previous byte's tx_done.
                state_d = ST_WAIT_DONE;
            end
            ST_STOP: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counter restarts on every state entry and advances only in timed states.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_WAIT_DONE) || (state_q == ST_WAIT_RDY) ||
                     (state_q == ST_GAP)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end

        // Outputs are decoded from the state being entered so they are flops.
        cmd_ready_d   = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE) && (state_d != ST_DONE);
        m_en_d        = (state_d != ST_IDLE) && (state_d != ST_DONE);
        m_start_d     = (state_d == ST_START);
        m_stop_d      = (state_d == ST_STOP);
        done_d        = (state_d == ST_DONE);
        timeout_err_d = (state_d == ST_DONE) && abort_d;
    end

    // State and output registers; reset drops every master pin at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            data_q        <= '0;
            byte_cnt_q    <= '0;
            cnt_q         <= '0;
            abort_q       <= 1'b0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            m_en_q        <= 1'b0;
            m_start_q     <= 1'b0;
            m_stop_q      <= 1'b0;
            m_tx_data_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            data_q        <= data_d;
            byte_cnt_q    <= byte_cnt_d;
            cnt_q         <= cnt_d;
            abort_q       <= abort_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            m_en_q        <= m_en_d;
            m_start_q     <= m_start_d;
            m_stop_q      <= m_stop_d;
            m_tx_data_q   <= m_tx_data_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign m_en        = m_en_q;
    assign m_start     = m_start_q;
    assign m_stop      = m_stop_q;
    assign m_tx_data   = m_tx_data_q;

endmodule
